// File: rtl/execute_unit.sv
// Execute stage: ALU, forwarding muxes and a multi-cycle multiply/divide unit.
// Optional operand forwarding is compiled in with `define EXECUTE_UNIT_FWD_EN.
module execute_unit #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  localparam int SHAMT_W = $clog2(DATA_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_d,
  output logic               ready_e,
  input  logic               stall_in,
  input  logic               flush,
  input  logic [DATA_W-1:0]  rd1_d,
  input  logic [DATA_W-1:0]  rd2_d,
  input  logic [DATA_W-1:0]  imm_d,
  input  logic [SHAMT_W-1:0] shamt_d,
  input  logic [REG_AW-1:0]  rt_d,
  input  logic [REG_AW-1:0]  rd_d,
  input  logic               reg_write_d,
  input  logic               mem_to_reg_d,
  input  logic               mem_write_d,
  input  logic               branch_d,
  input  logic               reg_dst_d,
  input  logic [3:0]         alu_control_d,
  input  logic [1:0]         alu_src_d,
  input  logic [1:0]         md_op_d,
  input  logic [1:0]         fwd_a_sel,
  input  logic [1:0]         fwd_b_sel,
  input  logic [DATA_W-1:0]  fwd_mem_data,
  input  logic [DATA_W-1:0]  fwd_wb_data,
  output logic [DATA_W-1:0]  alu_out_e,
  output logic [DATA_W-1:0]  write_data_e,
  output logic [REG_AW-1:0]  write_reg_e,
  output logic               reg_write_e,
  output logic               mem_to_reg_e,
  output logic               mem_write_e,
  output logic               branch_e,
  output logic               zero_e,
  output logic               valid_e,
  output logic               busy_e
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [1:0] MD_NONE = 2'b00;
  localparam logic [1:0] MD_MUL  = 2'b01;
  localparam logic [1:0] MD_DIVU = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    count;
  logic                stage_valid;
  logic [DATA_W-1:0]   e_rd1;
  logic [DATA_W-1:0]   e_rd2;
  logic [DATA_W-1:0]   e_imm;
  logic [SHAMT_W-1:0]  e_shamt;
  logic [REG_AW-1:0]   e_rt;
  logic [REG_AW-1:0]   e_rd;
  logic                e_reg_write;
  logic                e_mem_to_reg;
  logic                e_mem_write;
  logic                e_branch;
  logic                e_reg_dst;
  logic [3:0]          e_alu_ctl;
  logic [1:0]          e_alu_src;
  logic [1:0]          e_md_op;

  // md_a: multiplicand / dividend-quotient shifter; md_b: multiplier / divisor; md_acc: product / remainder
  logic [DATA_W-1:0]   md_a;
  logic [DATA_W-1:0]   md_b;
  logic [DATA_W-1:0]   md_acc;

  logic [DATA_W-1:0]   op_a;
  logic [DATA_W-1:0]   op_b;
  logic [DATA_W-1:0]   src1;
  logic [DATA_W-1:0]   src2;
  logic [SHAMT_W-1:0]  shift;
  logic [DATA_W-1:0]   alu_result;
  logic [DATA_W-1:0]   md_result;
  logic [DATA_W:0]     div_trial;
  logic [DATA_W-1:0]   div_diff;
  logic                div_ge;
  logic                is_md;

`ifdef EXECUTE_UNIT_FWD_EN
  // Operand forwarding from the memory and write-back stages.
  always_comb begin
    op_a = e_rd1;
    op_b = e_rd2;
    case (fwd_a_sel)
      2'b01:   op_a = fwd_mem_data;
      2'b10:   op_a = fwd_wb_data;
      default: op_a = e_rd1;
    endcase
    case (fwd_b_sel)
      2'b01:   op_b = fwd_mem_data;
      2'b10:   op_b = fwd_wb_data;
      default: op_b = e_rd2;
    endcase
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_a_sel, fwd_b_sel, fwd_mem_data, fwd_wb_data};
  assign op_a = e_rd1;
  assign op_b = e_rd2;
`endif

  assign src1  = e_alu_src[0] ? {{(DATA_W-SHAMT_W){1'b0}}, e_shamt} : op_a;
  assign src2  = e_alu_src[1] ? e_imm : op_b;
  assign shift = src1[SHAMT_W-1:0];

  // Single-cycle ALU.
  always_comb begin
    alu_result = {DATA_W{1'b0}};
    case (e_alu_ctl)
      4'd0:    alu_result = src1 + src2;
      4'd1:    alu_result = src1 - src2;
      4'd2:    alu_result = src1 & src2;
      4'd3:    alu_result = src1 | src2;
      4'd4:    alu_result = src1 ^ src2;
      4'd5:    alu_result = ~(src1 | src2);
      4'd6:    alu_result = {{(DATA_W-1){1'b0}}, ($signed(src1) < $signed(src2))};
      4'd7:    alu_result = {{(DATA_W-1){1'b0}}, (src1 < src2)};
      4'd8:    alu_result = src2 << shift;
      4'd9:    alu_result = src2 >> shift;
      4'd10:   alu_result = $signed(src2) >>> shift;
      default: alu_result = {DATA_W{1'b0}};
    endcase
  end

  // Restoring-divide step: shift the next dividend bit into the partial remainder and try to subtract.
  assign div_trial = {md_acc, md_a[DATA_W-1]};
  assign div_ge    = (div_trial >= {1'b0, md_b});
  assign div_diff  = div_trial[DATA_W-1:0] - md_b;

  assign md_result = (e_md_op == MD_DIVU) ? md_a : md_acc;
  assign is_md     = (e_md_op != MD_NONE);

  assign busy_e  = (state == ST_RUN);
  assign ready_e = (state != ST_RUN) && !stall_in;
  assign valid_e = stage_valid && (!is_md || (state == ST_DONE));

  assign alu_out_e    = valid_e ? (is_md ? md_result : alu_result) : {DATA_W{1'b0}};
  assign write_data_e = valid_e ? op_b : {DATA_W{1'b0}};
  assign write_reg_e  = valid_e ? (e_reg_dst ? e_rd : e_rt) : {REG_AW{1'b0}};
  assign reg_write_e  = valid_e && e_reg_write;
  assign mem_to_reg_e = valid_e && e_mem_to_reg;
  assign mem_write_e  = valid_e && e_mem_write;
  assign branch_e     = valid_e && e_branch;
  assign zero_e       = valid_e && (alu_out_e == {DATA_W{1'b0}});

  // Stage registers and multiply/divide sequencer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      count        <= {CNT_W{1'b0}};
      stage_valid  <= 1'b0;
      e_rd1        <= {DATA_W{1'b0}};
      e_rd2        <= {DATA_W{1'b0}};
      e_imm        <= {DATA_W{1'b0}};
      e_shamt      <= {SHAMT_W{1'b0}};
      e_rt         <= {REG_AW{1'b0}};
      e_rd         <= {REG_AW{1'b0}};
      e_reg_write  <= 1'b0;
      e_mem_to_reg <= 1'b0;
      e_mem_write  <= 1'b0;
      e_branch     <= 1'b0;
      e_reg_dst    <= 1'b0;
      e_alu_ctl    <= 4'd0;
      e_alu_src    <= 2'b00;
      e_md_op      <= 2'b00;
      md_a         <= {DATA_W{1'b0}};
      md_b         <= {DATA_W{1'b0}};
      md_acc       <= {DATA_W{1'b0}};
    end else if (flush) begin
      stage_valid <= 1'b0;
      state       <= ST_IDLE;
    end else begin
      if (ready_e) begin
        stage_valid  <= valid_d;
        e_rd1        <= rd1_d;
        e_rd2        <= rd2_d;
        e_imm        <= imm_d;
        e_shamt      <= shamt_d;
        e_rt         <= rt_d;
        e_rd         <= rd_d;
        e_reg_write  <= reg_write_d;
        e_mem_to_reg <= mem_to_reg_d;
        e_mem_write  <= mem_write_d;
        e_branch     <= branch_d;
        e_reg_dst    <= reg_dst_d;
        e_alu_ctl    <= alu_control_d;
        e_alu_src    <= alu_src_d;
        e_md_op      <= md_op_d;
      end
      case (state)
        ST_RUN: begin
          count <= count - CNT_W'(1);
          if (e_md_op == MD_MUL) begin
            md_acc <= md_acc + (md_b[0] ? md_a : {DATA_W{1'b0}});
            md_a   <= md_a << 1;
            md_b   <= md_b >> 1;
          end else begin
            md_acc <= div_ge ? div_diff : div_trial[DATA_W-1:0];
            md_a   <= {md_a[DATA_W-2:0], div_ge};
          end
          if (count == CNT_W'(1)) begin
            state <= ST_DONE;
          end
        end
        default: begin
          if (ready_e) begin
            if (valid_d && (md_op_d != MD_NONE)) begin
              state  <= ST_RUN;
              count  <= CNT_W'(DATA_W);
              md_a   <= rd1_d;
              md_b   <= rd2_d;
              md_acc <= {DATA_W{1'b0}};
            end else begin
              state <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule
